// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's-tour command sequencer.
//   state_t          : sequencer FSM states
//   OP_*             : command opcodes for the vertical / horizontal legs
//   HDG_*            : command heading codes
//   RESP_*           : response bytes returned toward the UART
//   NUM_MOVES        : number of moves replayed from the solver
package tour_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VERT,
        S_HOLDV,
        S_HORZ,
        S_HOLDH
    } state_t;

    localparam logic [3:0] OP_MOVE         = 4'h2;
    localparam logic [3:0] OP_MOVE_FANFARE = 4'h3;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    localparam int         NUM_MOVES = 24;
    localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

endpackage

// File: rtl/knight_move_decode.sv
// Combinational decode of a one-hot knight move into two motion commands.
//   move     in  8   one-hot move (dx,dy) from the solver
//   vert_cmd out 16  vertical leg: {OP_MOVE, heading, squares}
//   horz_cmd out 16  horizontal leg: {OP_MOVE_FANFARE, heading, squares}
// A move that is not one-hot yields zero-length northward legs.
module knight_move_decode
    import tour_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] vert_cmd,
    output logic [15:0] horz_cmd
);

    logic [7:0] vert_hdg;
    logic [7:0] horz_hdg;
    logic [3:0] vert_sq;
    logic [3:0] horz_sq;

    always_comb begin
        vert_hdg = HDG_N;
        horz_hdg = HDG_N;
        vert_sq  = 4'd0;
        horz_sq  = 4'd0;
        case (move)
            8'h01: begin vert_hdg = HDG_N; vert_sq = 4'd1; horz_hdg = HDG_E; horz_sq = 4'd2; end
            8'h02: begin vert_hdg = HDG_N; vert_sq = 4'd2; horz_hdg = HDG_E; horz_sq = 4'd1; end
            8'h04: begin vert_hdg = HDG_N; vert_sq = 4'd2; horz_hdg = HDG_W; horz_sq = 4'd1; end
            8'h08: begin vert_hdg = HDG_N; vert_sq = 4'd1; horz_hdg = HDG_W; horz_sq = 4'd2; end
            8'h10: begin vert_hdg = HDG_S; vert_sq = 4'd1; horz_hdg = HDG_W; horz_sq = 4'd2; end
            8'h20: begin vert_hdg = HDG_S; vert_sq = 4'd2; horz_hdg = HDG_W; horz_sq = 4'd1; end
            8'h40: begin vert_hdg = HDG_S; vert_sq = 4'd2; horz_hdg = HDG_E; horz_sq = 4'd1; end
            8'h80: begin vert_hdg = HDG_S; vert_sq = 4'd1; horz_hdg = HDG_E; horz_sq = 4'd2; end
            default: ;
        endcase
    end

    assign vert_cmd = {OP_MOVE, vert_hdg, vert_sq};
    assign horz_cmd = {OP_MOVE_FANFARE, horz_hdg, horz_sq};

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Replays a solved knight's tour as motion commands; transparent UART
// passthrough while idle.
//   clk, rst          clock, synchronous active-high reset
//   start_tour        pulse: solver finished, begin replay
//   move / mv_indx    one-hot move read back from the solver at mv_indx
//   cmd_UART, cmd_rdy_UART, clr_cmd_rdy_UART   UART-side command handshake
//   cmd, cmd_rdy, clr_cmd_rdy, send_resp       command-processor handshake
//   resp              response byte for UART transmit
//
// state | meaning
// IDLE  | UART commands pass straight through
// VERT  | vertical leg offered (cmd_rdy high)
// HOLDV | vertical leg accepted, waiting for execution to finish
// HORZ  | horizontal leg offered (cmd_rdy high)
// HOLDH | horizontal leg accepted, waiting; then next move or done
module tour_cmd_sequencer
    import tour_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  indx_nxt;
    logic [15:0] vert_cmd;
    logic [15:0] horz_cmd;
    logic        last_move;

    knight_move_decode u_decode (
        .move     (move),
        .vert_cmd (vert_cmd),
        .horz_cmd (horz_cmd)
    );

    assign last_move = (mv_indx == LAST_INDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            mv_indx <= 5'd0;
        end else begin
            state   <= state_nxt;
            mv_indx <= indx_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        indx_nxt         = mv_indx;
        cmd              = vert_cmd;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = RESP_BUSY;
        case (state)
            S_IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = RESP_DONE;
                if (start_tour) begin
                    indx_nxt  = 5'd0;
                    state_nxt = S_VERT;
                end
            end
            S_VERT: begin
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_nxt = S_HOLDV;
            end
            S_HOLDV: begin
                if (send_resp) state_nxt = S_HORZ;
            end
            S_HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_nxt = S_HOLDH;
            end
            S_HOLDH: begin
                cmd = horz_cmd;
                if (last_move) resp = RESP_DONE;
                if (send_resp) begin
                    if (last_move) begin
                        state_nxt = S_IDLE;
                    end else begin
                        indx_nxt  = mv_indx + 5'd1;
                        state_nxt = S_VERT;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
module tb_tour_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  move_tbl [0:31];
    logic [15:0] exp_v    [0:31];
    logic [15:0] exp_h    [0:31];

    tour_cmd_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .start_tour       (start_tour),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .resp             (resp)
    );

    always #5 clk = ~clk;

    // solver model: move table read at the index the sequencer presents
    assign move = move_tbl[mv_indx];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one full move (both legs) starting in VERT at index i.
    task automatic do_move(input int i);
        logic [7:0] exp_resp;
        chk("mv_indx", 16'(mv_indx), 16'(i));
        chk("vert_cmd", cmd, exp_v[i]);
        chk("vert_rdy", 16'(cmd_rdy), 16'd1);
        chk("vert_resp", 16'(resp), 16'h5A);
        clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0; #1;
        chk("holdv_rdy", 16'(cmd_rdy), 16'd0);
        chk("holdv_cmd", cmd, exp_v[i]);
        send_resp = 1'b1; tick(); send_resp = 1'b0; #1;
        chk("horz_cmd", cmd, exp_h[i]);
        chk("horz_rdy", 16'(cmd_rdy), 16'd1);
        clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0; #1;
        exp_resp = (i == 23) ? 8'hA5 : 8'h5A;
        chk("holdh_rdy", 16'(cmd_rdy), 16'd0);
        chk("holdh_resp", 16'(resp), 16'(exp_resp));
        send_resp = 1'b1; tick(); send_resp = 1'b0; #1;
    endtask

    initial begin
        // hand-computed leg commands for each one-hot bit
        logic [15:0] hv [0:7];
        logic [15:0] hh [0:7];
        hv[0] = 16'h2001; hh[0] = 16'h3BF2;
        hv[1] = 16'h2002; hh[1] = 16'h3BF1;
        hv[2] = 16'h2002; hh[2] = 16'h33F1;
        hv[3] = 16'h2001; hh[3] = 16'h33F2;
        hv[4] = 16'h27F1; hh[4] = 16'h33F2;
        hv[5] = 16'h27F2; hh[5] = 16'h33F1;
        hv[6] = 16'h27F2; hh[6] = 16'h3BF1;
        hv[7] = 16'h27F1; hh[7] = 16'h3BF2;
        for (int i = 0; i < 32; i++) begin
            move_tbl[i] = 8'h01 << (i % 8);
            exp_v[i]    = hv[i % 8];
            exp_h[i]    = hh[i % 8];
        end
        // non-one-hot entries: zero-length northward legs
        move_tbl[10] = 8'h03; exp_v[10] = 16'h2000; exp_h[10] = 16'h3000;
        move_tbl[11] = 8'h00; exp_v[11] = 16'h2000; exp_h[11] = 16'h3000;

        rst = 1'b1; start_tour = 1'b0; cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0;
        clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        tick(); tick();
        rst = 1'b0; #1;
        chk("rst_indx", 16'(mv_indx), 16'd0);
        chk("rst_resp", 16'(resp), 16'hA5);
        chk("rst_rdy", 16'(cmd_rdy), 16'd0);

        // IDLE passthrough
        cmd_UART = 16'h2003; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1; #1;
        chk("pt_cmd", cmd, 16'h2003);
        chk("pt_rdy", 16'(cmd_rdy), 16'd1);
        chk("pt_clr", 16'(clr_cmd_rdy_UART), 16'd1);
        chk("pt_resp", 16'(resp), 16'hA5);
        tick();
        clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0; #1;
        chk("pt_rdy_low", 16'(cmd_rdy), 16'd0);

        // start: VERT the next cycle; UART side ignored
        start_tour = 1'b1; tick(); start_tour = 1'b0;
        cmd_rdy_UART = 1'b1; cmd_UART = 16'hFFFF; #1;
        chk("v0_cmd", cmd, 16'h2001);
        chk("v0_rdy", 16'(cmd_rdy), 16'd1);
        chk("v0_resp", 16'(resp), 16'h5A);
        // send_resp in VERT ignored
        send_resp = 1'b1; tick(); send_resp = 1'b0; #1;
        chk("v0_sr_ign", 16'(cmd_rdy), 16'd1);
        chk("v0_sr_cmd", cmd, 16'h2001);
        clr_cmd_rdy = 1'b1; #1;
        chk("v0_clr_uart", 16'(clr_cmd_rdy_UART), 16'd0);
        tick(); clr_cmd_rdy = 1'b0; #1;
        chk("hv0_rdy", 16'(cmd_rdy), 16'd0);
        chk("hv0_cmd", cmd, 16'h2001);
        // start_tour / UART activity in HOLDV ignored
        start_tour = 1'b1; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1; #1;
        chk("hv0_clr_uart", 16'(clr_cmd_rdy_UART), 16'd0);
        tick(); start_tour = 1'b0; cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b0; #1;
        chk("hv0_hold_rdy", 16'(cmd_rdy), 16'd0);
        chk("hv0_hold_cmd", cmd, 16'h2001);
        chk("hv0_hold_idx", 16'(mv_indx), 16'd0);
        send_resp = 1'b1; tick(); send_resp = 1'b0; #1;
        chk("h0_cmd", cmd, 16'h3BF2);
        chk("h0_rdy", 16'(cmd_rdy), 16'd1);
        chk("h0_resp", 16'(resp), 16'h5A);
        // simultaneous clr and send in HORZ: only clr honoured
        clr_cmd_rdy = 1'b1; send_resp = 1'b1; tick(); #1;
        chk("hh0_rdy", 16'(cmd_rdy), 16'd0);
        chk("hh0_idx", 16'(mv_indx), 16'd0);
        chk("hh0_cmd", cmd, 16'h3BF2);
        tick(); clr_cmd_rdy = 1'b0; send_resp = 1'b0; #1;
        chk("m1_idx", 16'(mv_indx), 16'd1);
        chk("m1_rdy", 16'(cmd_rdy), 16'd1);

        // rest of the tour
        for (int i = 1; i < 24; i++) do_move(i);
        chk("end_idx", 16'(mv_indx), 16'd23);
        chk("end_resp", 16'(resp), 16'hA5);
        cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1; #1;
        chk("end_pt_cmd", cmd, 16'h1234);
        chk("end_pt_rdy", 16'(cmd_rdy), 16'd1);
        cmd_rdy_UART = 1'b0;

        // second tour, reset in HORZ at index 7
        start_tour = 1'b1; tick(); start_tour = 1'b0; #1;
        for (int i = 0; i < 7; i++) do_move(i);
        chk("t2_idx", 16'(mv_indx), 16'd7);
        clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
        send_resp = 1'b1; tick(); send_resp = 1'b0; #1;
        chk("t2_horz_cmd", cmd, 16'h3BF2);
        rst = 1'b1; tick(); rst = 1'b0;
        cmd_UART = 16'h2ABC; cmd_rdy_UART = 1'b1; #1;
        chk("rst2_idx", 16'(mv_indx), 16'd0);
        chk("rst2_cmd", cmd, 16'h2ABC);
        chk("rst2_rdy", 16'(cmd_rdy), 16'd1);
        chk("rst2_resp", 16'(resp), 16'hA5);
        cmd_rdy_UART = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
